// File: rtl/tree_node_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tree_node_pkg
// Description : Shared types and width helpers for the tree node controller.
//               node_state_e - controller FSM states
//               node_mode_e  - child dispatch mode (broadcast / sequential)
// Revision    : 1.0 - initial release
// ============================================================================
package tree_node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } node_state_e;

    typedef enum logic {
        BROADCAST  = 1'b0,
        SEQUENTIAL = 1'b1
    } node_mode_e;

    // Counter wide enough to hold max_val; never narrower than one bit so a
    // disabled timeout still has a legal (constant-zero) register.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 0) ? 1 : $clog2(max_val + 1);
    endfunction

    // Child pointer width; a single child still needs a one-bit pointer.
    function automatic int ptr_width(input int num);
        return (num <= 1) ? 1 : $clog2(num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tree_node_done_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tree_node_done_tracker
// Description : Issued / done / error mask registers for one tree node.
//               Produces next-cycle mask values so the controller can react
//               to an acceptance and a done pulse landing in the same cycle.
// Ports       : clear        - zero all masks (new transaction)
//               capture      - masks update only while this is high
//               accept       - per-child request handshake this cycle
//               done_in/err_in - per-child completion pulse and its error
//               ptr          - child pointer for ptr_done_next
//               *_next       - mask values after this clock edge
//               all_done_next / ptr_done_next - completion flags
// Revision    : 1.0 - initial release
// ============================================================================
module tree_node_done_tracker
    import tree_node_pkg::*;
#(
    parameter int NUM_CHILDREN = 5,
    parameter int PTR_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    capture,
    input  logic [NUM_CHILDREN-1:0] accept,
    input  logic [NUM_CHILDREN-1:0] done_in,
    input  logic [NUM_CHILDREN-1:0] err_in,
    input  logic [PTR_W-1:0]        ptr,
    output logic [NUM_CHILDREN-1:0] issued_next,
    output logic [NUM_CHILDREN-1:0] done_next,
    output logic [NUM_CHILDREN-1:0] err_next,
    output logic                    all_done_next,
    output logic                    ptr_done_next
);

    logic [NUM_CHILDREN-1:0] r_issued;
    logic [NUM_CHILDREN-1:0] r_done;
    logic [NUM_CHILDREN-1:0] r_err;
    logic [NUM_CHILDREN-1:0] w_hit;

    // A done pulse counts only for a child that is issued (including one
    // being accepted this very cycle) and not already done.
    always_comb begin
        issued_next = r_issued;
        done_next   = r_done;
        err_next    = r_err;
        w_hit       = '0;
        if (clear) begin
            issued_next = '0;
            done_next   = '0;
            err_next    = '0;
        end else if (capture) begin
            issued_next = r_issued | accept;
            w_hit       = done_in & issued_next & ~r_done;
            done_next   = r_done | w_hit;
            err_next    = r_err | (w_hit & err_in);
        end
    end

    assign all_done_next = &done_next;
    assign ptr_done_next = done_next[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued <= '0;
            r_done   <= '0;
            r_err    <= '0;
        end else begin
            r_issued <= issued_next;
            r_done   <= done_next;
            r_err    <= err_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tree_node_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tree_node_ctrl
// Description : Hierarchy node controller. Takes one command from the parent,
//               dispatches it to NUM_CHILDREN children (broadcast or one at a
//               time), gathers done/err pulses and returns one aggregated
//               response, optionally bounded by a cycle timeout.
// Ports       : up_req_*   - command from parent (ready decoded from state)
//               up_rsp_*   - registered aggregated response to parent
//               child_req_*- registered command to children, shared tag
//               child_done/child_err - per-child completion pulses
// Revision    : 1.0 - initial release
// ============================================================================
module tree_node_ctrl
    import tree_node_pkg::*;
#(
    parameter int NUM_CHILDREN   = 5,
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SEQ_MODE       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up_req_valid,
    output logic                    up_req_ready,
    input  logic [TAG_W-1:0]        up_req_tag,
    output logic                    up_rsp_valid,
    input  logic                    up_rsp_ready,
    output logic [TAG_W-1:0]        up_rsp_tag,
    output logic [NUM_CHILDREN-1:0] up_rsp_done_mask,
    output logic [NUM_CHILDREN-1:0] up_rsp_err_mask,
    output logic                    up_rsp_timeout,
    output logic [NUM_CHILDREN-1:0] child_req_valid,
    input  logic [NUM_CHILDREN-1:0] child_req_ready,
    output logic [TAG_W-1:0]        child_req_tag,
    input  logic [NUM_CHILDREN-1:0] child_done,
    input  logic [NUM_CHILDREN-1:0] child_err
);

    localparam int              CNT_W     = cnt_width(TIMEOUT_CYCLES);
    localparam int              PTR_W     = ptr_width(NUM_CHILDREN);
    localparam node_mode_e      c_mode    = (SEQ_MODE != 0) ? SEQUENTIAL : BROADCAST;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(NUM_CHILDREN - 1);

    node_state_e             r_state;
    node_state_e             w_state_n;
    logic [TAG_W-1:0]        r_tag;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        w_ptr_n;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [NUM_CHILDREN-1:0] r_child_req_valid;
    logic [NUM_CHILDREN-1:0] w_child_req_valid_n;
    logic                    r_up_rsp_valid;
    logic [TAG_W-1:0]        r_up_rsp_tag;
    logic [NUM_CHILDREN-1:0] r_up_rsp_done_mask;
    logic [NUM_CHILDREN-1:0] r_up_rsp_err_mask;
    logic                    r_up_rsp_timeout;

    logic                    w_start;
    logic                    w_active;
    logic                    w_to_resp;
    logic                    w_timeout_flag;
    logic                    w_timeout_hit;
    logic [NUM_CHILDREN-1:0] w_accept;
    logic [NUM_CHILDREN-1:0] w_issued_next;
    logic [NUM_CHILDREN-1:0] w_done_next;
    logic [NUM_CHILDREN-1:0] w_err_next;
    logic                    w_all_done_next;
    logic                    w_ptr_done_next;

    assign w_start  = (r_state == IDLE) && up_req_valid;
    assign w_active = (r_state == ISSUE) || (r_state == WAIT);
    assign w_accept = r_child_req_valid & child_req_ready;

    // Saturating count; with the timeout disabled c_cnt_max is 0, which pins
    // the counter at 0.
    assign w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);

    // The limit fires on the edge where the counter would reach
    // TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES cycles are spent in
    // ISSUE/WAIT before the response is raised.
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && w_active &&
                           (w_cnt_next == c_cnt_max);

    tree_node_done_tracker #(
        .NUM_CHILDREN (NUM_CHILDREN),
        .PTR_W        (PTR_W)
    ) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_start),
        .capture       (w_active),
        .accept        (w_accept),
        .done_in       (child_done),
        .err_in        (child_err),
        .ptr           (r_ptr),
        .issued_next   (w_issued_next),
        .done_next     (w_done_next),
        .err_next      (w_err_next),
        .all_done_next (w_all_done_next),
        .ptr_done_next (w_ptr_done_next)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and next registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n           = r_state;
        w_ptr_n             = r_ptr;
        w_child_req_valid_n = r_child_req_valid;
        w_to_resp           = 1'b0;
        w_timeout_flag      = 1'b0;

        case (r_state)
            IDLE: begin
                if (up_req_valid) begin
                    w_state_n           = ISSUE;
                    w_ptr_n             = '0;
                    w_child_req_valid_n = (c_mode == SEQUENTIAL) ?
                                          NUM_CHILDREN'(1) : '1;
                end
            end

            ISSUE, WAIT: begin
                if (c_mode == SEQUENTIAL) begin
                    if (w_ptr_done_next) begin
                        if (r_ptr == c_ptr_last) begin
                            w_to_resp = 1'b1;
                        end else begin
                            w_ptr_n             = r_ptr + PTR_W'(1);
                            w_state_n           = ISSUE;
                            w_child_req_valid_n = NUM_CHILDREN'(1) << w_ptr_n;
                        end
                    end else if (w_accept[r_ptr]) begin
                        w_state_n           = WAIT;
                        w_child_req_valid_n = '0;
                    end
                end else begin
                    if (w_all_done_next) begin
                        w_to_resp = 1'b1;
                    end else begin
                        w_child_req_valid_n = ~w_issued_next;
                        w_state_n           = (&w_issued_next) ? WAIT : ISSUE;
                    end
                end

                // Completion takes precedence over a coincident timeout.
                if (!w_to_resp && w_timeout_hit) begin
                    w_to_resp      = 1'b1;
                    w_timeout_flag = 1'b1;
                end

                if (w_to_resp) begin
                    w_state_n           = RESP;
                    w_child_req_valid_n = '0;
                end
            end

            RESP: begin
                if (up_rsp_ready) begin
                    w_state_n = IDLE;
                end
            end

            default: begin
                w_state_n           = IDLE;
                w_child_req_valid_n = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag              <= '0;
            r_ptr              <= '0;
            r_cnt              <= '0;
            r_child_req_valid  <= '0;
            r_up_rsp_valid     <= 1'b0;
            r_up_rsp_tag       <= '0;
            r_up_rsp_done_mask <= '0;
            r_up_rsp_err_mask  <= '0;
            r_up_rsp_timeout   <= 1'b0;
        end else begin
            r_ptr             <= w_ptr_n;
            r_child_req_valid <= w_child_req_valid_n;

            if (w_start) begin
                r_tag <= up_req_tag;
                r_cnt <= '0;
            end else if (w_active) begin
                r_cnt <= w_cnt_next;
            end

            if (w_to_resp) begin
                r_up_rsp_valid     <= 1'b1;
                r_up_rsp_tag       <= r_tag;
                r_up_rsp_done_mask <= w_done_next;
                r_up_rsp_err_mask  <= w_err_next;
                r_up_rsp_timeout   <= w_timeout_flag;
            end else if ((r_state == RESP) && up_rsp_ready) begin
                r_up_rsp_valid <= 1'b0;
            end
        end
    end

    assign up_req_ready     = (r_state == IDLE);
    assign up_rsp_valid     = r_up_rsp_valid;
    assign up_rsp_tag       = r_up_rsp_tag;
    assign up_rsp_done_mask = r_up_rsp_done_mask;
    assign up_rsp_err_mask  = r_up_rsp_err_mask;
    assign up_rsp_timeout   = r_up_rsp_timeout;
    assign child_req_valid  = r_child_req_valid;
    assign child_req_tag    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_tree_node_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tree_node_ctrl
// Description : Directed self-checking bench for tree_node_ctrl. Instance A is
//               broadcast with a 10-cycle timeout, instance B is sequential.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tree_node_ctrl;

    localparam int N = 5;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: broadcast, TIMEOUT_CYCLES = 10
    logic         a_up_req_valid, a_up_req_ready, a_up_rsp_valid, a_up_rsp_ready;
    logic [W-1:0] a_up_req_tag, a_up_rsp_tag, a_child_req_tag;
    logic [N-1:0] a_done_mask, a_err_mask, a_child_req_valid, a_child_req_ready;
    logic [N-1:0] a_child_done, a_child_err;
    logic         a_up_rsp_timeout;

    // Instance B: sequential, TIMEOUT_CYCLES = 255
    logic         b_up_req_valid, b_up_req_ready, b_up_rsp_valid, b_up_rsp_ready;
    logic [W-1:0] b_up_req_tag, b_up_rsp_tag, b_child_req_tag;
    logic [N-1:0] b_done_mask, b_err_mask, b_child_req_valid, b_child_req_ready;
    logic [N-1:0] b_child_done, b_child_err;
    logic         b_up_rsp_timeout;

    tree_node_ctrl #(.NUM_CHILDREN(N), .TAG_W(W), .TIMEOUT_CYCLES(10), .SEQ_MODE(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .up_req_valid(a_up_req_valid), .up_req_ready(a_up_req_ready), .up_req_tag(a_up_req_tag),
        .up_rsp_valid(a_up_rsp_valid), .up_rsp_ready(a_up_rsp_ready), .up_rsp_tag(a_up_rsp_tag),
        .up_rsp_done_mask(a_done_mask), .up_rsp_err_mask(a_err_mask), .up_rsp_timeout(a_up_rsp_timeout),
        .child_req_valid(a_child_req_valid), .child_req_ready(a_child_req_ready),
        .child_req_tag(a_child_req_tag), .child_done(a_child_done), .child_err(a_child_err)
    );

    tree_node_ctrl #(.NUM_CHILDREN(N), .TAG_W(W), .TIMEOUT_CYCLES(255), .SEQ_MODE(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .up_req_valid(b_up_req_valid), .up_req_ready(b_up_req_ready), .up_req_tag(b_up_req_tag),
        .up_rsp_valid(b_up_rsp_valid), .up_rsp_ready(b_up_rsp_ready), .up_rsp_tag(b_up_rsp_tag),
        .up_rsp_done_mask(b_done_mask), .up_rsp_err_mask(b_err_mask), .up_rsp_timeout(b_up_rsp_timeout),
        .child_req_valid(b_child_req_valid), .child_req_ready(b_child_req_ready),
        .child_req_tag(b_child_req_tag), .child_done(b_child_done), .child_err(b_child_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        a_up_req_valid = 1'b0; a_up_req_tag = '0; a_up_rsp_ready = 1'b1;
        a_child_req_ready = '0; a_child_done = '0; a_child_err = '0;
        b_up_req_valid = 1'b0; b_up_req_tag = '0; b_up_rsp_ready = 1'b1;
        b_child_req_ready = '0; b_child_done = '0; b_child_err = '0;

        step(); step();
        // Reset state
        chk("rst_a_req_ready", 32'(a_up_req_ready), 32'd1);
        chk("rst_a_child_valid", 32'(a_child_req_valid), 32'h0);
        chk("rst_a_rsp_valid", 32'(a_up_rsp_valid), 32'd0);
        chk("rst_a_done_mask", 32'(a_done_mask), 32'h0);
        chk("rst_b_req_ready", 32'(b_up_req_ready), 32'd1);
        chk("rst_b_child_valid", 32'(b_child_req_valid), 32'h0);
        rst = 1'b0;
        step();

        // ---------------- Broadcast, all ready, tag 0x3C ----------------
        a_child_req_ready = 5'h1F;
        a_up_req_valid = 1'b1; a_up_req_tag = 8'h3C;
        step();                                  // T+1
        a_up_req_valid = 1'b0;
        chk("bc_valid_t1", 32'(a_child_req_valid), 32'h1F);
        chk("bc_tag_t1", 32'(a_child_req_tag), 32'h3C);
        chk("bc_req_ready_busy", 32'(a_up_req_ready), 32'd0);
        step();                                  // T+2
        chk("bc_valid_t2", 32'(a_child_req_valid), 32'h0);
        step();                                  // T+3
        a_child_done = 5'h1F;
        chk("bc_no_rsp_t3", 32'(a_up_rsp_valid), 32'd0);
        step();                                  // T+4
        a_child_done = '0;
        chk("bc_rsp_valid_t4", 32'(a_up_rsp_valid), 32'd1);
        chk("bc_rsp_tag", 32'(a_up_rsp_tag), 32'h3C);
        chk("bc_done_mask", 32'(a_done_mask), 32'h1F);
        chk("bc_err_mask", 32'(a_err_mask), 32'h0);
        chk("bc_timeout", 32'(a_up_rsp_timeout), 32'd0);
        step();
        chk("bc_rsp_dropped", 32'(a_up_rsp_valid), 32'd0);
        chk("bc_back_idle", 32'(a_up_req_ready), 32'd1);

        // ---------------- Broadcast with back-pressure on child 2 ----------------
        a_child_req_ready = 5'b11011;
        a_up_req_valid = 1'b1; a_up_req_tag = 8'h5A;
        step();                                  // P1
        a_up_req_valid = 1'b0;
        chk("bp_valid_p1", 32'(a_child_req_valid), 32'h1F);
        step();                                  // P2
        chk("bp_valid_p2", 32'(a_child_req_valid), 32'h04);
        a_child_done = 5'b11011; a_child_err = 5'b10000;
        step();                                  // P3
        a_child_done = '0; a_child_err = '0;
        chk("bp_valid_p3", 32'(a_child_req_valid), 32'h04);
        chk("bp_no_rsp_p3", 32'(a_up_rsp_valid), 32'd0);
        step();                                  // P4
        chk("bp_valid_p4", 32'(a_child_req_valid), 32'h04);
        step();                                  // P5
        a_child_req_ready = 5'h1F;
        chk("bp_valid_p5", 32'(a_child_req_valid), 32'h04);
        step();                                  // P6
        chk("bp_valid_p6", 32'(a_child_req_valid), 32'h0);
        chk("bp_wait_child2", 32'(a_up_rsp_valid), 32'd0);
        a_child_done = 5'b00100;
        step();                                  // P7
        a_child_done = '0;
        chk("bp_rsp_valid", 32'(a_up_rsp_valid), 32'd1);
        chk("bp_done_mask", 32'(a_done_mask), 32'h1F);
        chk("bp_err_mask", 32'(a_err_mask), 32'h10);
        chk("bp_timeout", 32'(a_up_rsp_timeout), 32'd0);
        step();

        // ---------------- Timeout (child 1 silent) + response stall ----------------
        a_up_rsp_ready = 1'b0;
        a_child_req_ready = 5'h1F;
        a_up_req_valid = 1'b1; a_up_req_tag = 8'h77;
        step();                                  // ISSUE entry
        a_up_req_valid = 1'b0;
        k = 0;
        while (!a_up_rsp_valid && k <= 30) begin
            step();
            k++;
            if (k == 1) a_child_done = 5'b11101;
            if (k == 2) a_child_done = '0;
        end
        chk("to_latency", 32'(k), 32'd10);
        chk("to_flag", 32'(a_up_rsp_timeout), 32'd1);
        chk("to_done_mask", 32'(a_done_mask), 32'h1D);
        chk("to_rsp_tag", 32'(a_up_rsp_tag), 32'h77);
        chk("to_child_valid", 32'(a_child_req_valid), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stall_rsp_valid", 32'(a_up_rsp_valid), 32'd1);
            chk("stall_done_mask", 32'(a_done_mask), 32'h1D);
            chk("stall_timeout", 32'(a_up_rsp_timeout), 32'd1);
            chk("stall_req_ready", 32'(a_up_req_ready), 32'd0);
        end
        a_up_rsp_ready = 1'b1;
        step();
        chk("stall_release_valid", 32'(a_up_rsp_valid), 32'd0);
        chk("stall_release_idle", 32'(a_up_req_ready), 32'd1);

        // ---------------- Reset mid-transaction ----------------
        a_child_req_ready = 5'b11011;
        a_up_req_valid = 1'b1; a_up_req_tag = 8'h11;
        step();
        a_up_req_valid = 1'b0;
        step();
        chk("rr_pre_valid", 32'(a_child_req_valid), 32'h04);
        #2 rst = 1'b1;
        #1;
        chk("rr_async_valid", 32'(a_child_req_valid), 32'h0);
        chk("rr_async_idle", 32'(a_up_req_ready), 32'd1);
        step();
        rst = 1'b0;
        a_child_req_ready = 5'h1F;
        a_up_req_valid = 1'b1; a_up_req_tag = 8'h22;
        step();
        a_up_req_valid = 1'b0;
        a_child_done = 5'h1F; a_child_err = 5'b00001;
        step();
        a_child_done = '0; a_child_err = '0;
        chk("rr_new_rsp_valid", 32'(a_up_rsp_valid), 32'd1);
        chk("rr_new_tag", 32'(a_up_rsp_tag), 32'h22);
        chk("rr_new_done", 32'(a_done_mask), 32'h1F);
        chk("rr_new_err", 32'(a_err_mask), 32'h01);
        step();

        // ---------------- Sequential mode ----------------
        b_child_req_ready = 5'h1F;
        b_up_req_valid = 1'b1; b_up_req_tag = 8'hA5;
        step();
        b_up_req_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("seq_issue_one", 32'(b_child_req_valid), 32'(1 << i));
            if (i == 1) b_child_done = 5'b01000;   // stray pulse from child 3
            step();
            b_child_done = 5'(1 << i);
            chk("seq_gap", 32'(b_child_req_valid), 32'h0);
            step();
            b_child_done = '0;
        end
        chk("seq_rsp_valid", 32'(b_up_rsp_valid), 32'd1);
        chk("seq_rsp_tag", 32'(b_up_rsp_tag), 32'hA5);
        chk("seq_done_mask", 32'(b_done_mask), 32'h1F);
        chk("seq_err_mask", 32'(b_err_mask), 32'h0);
        chk("seq_timeout", 32'(b_up_rsp_timeout), 32'd0);
        step();
        chk("seq_back_idle", 32'(b_up_req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
